uart_tx: RTL



---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_baud_tick.sv | 37 +++
 rtl/uart_tx.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive paths: state encoding,
// bit-period calculation and the idle line level.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam logic UART_IDLE_LEVEL = 1'b1;

    // Clock cycles per line bit, integer-truncated.
    function automatic int unsigned cycles_per_bit(input int unsigned clk_hz,
                                                   input int unsigned bit_rate);
        return clk_hz / bit_rate;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CYCLES_PER_BIT-1 and flags the last cycle of
// each bit. A synchronous restart holds the count at zero.
module uart_baud_tick #(
    parameter int unsigned CYCLES_PER_BIT = 5208
) (
    input  logic clk,
    input  logic resetn,
    input  logic restart,
    output logic bit_done_c
);

    localparam int unsigned CNT_W = $clog2(CYCLES_PER_BIT + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CYCLES_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        bit_done_c = 1'b0;
        cnt_d      = cnt_q + CNT_W'(1);
        if (restart) begin
            cnt_d = '0;
        end else if (cnt_q == LAST_CNT) begin
            bit_done_c = 1'b1;
            cnt_d      = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one byte per handshake, serialised LSB first as 8N1/8N2.
// Define UART_TX_PARITY_EN to append an even-parity bit before the stop bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned BIT_RATE     = 9600,
    parameter int unsigned CLK_HZ       = 50000000,
    parameter int unsigned PAYLOAD_BITS = 8,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    output logic                    uart_txd,
    output logic                    uart_tx_busy,
    input  logic                    uart_tx_en,
    input  logic [PAYLOAD_BITS-1:0] uart_tx_data
);

    localparam int unsigned CYCLES_PER_BIT = cycles_per_bit(CLK_HZ, BIT_RATE);
    localparam int unsigned IDX_W          = $clog2(PAYLOAD_BITS + 1);
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(PAYLOAD_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

    uart_state_e             state_q, state_d;
    logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    txd_q, txd_d;
    logic                    busy_q, busy_d;
    logic                    restart_c;
    logic                    bit_done_c;
`ifdef UART_TX_PARITY_EN
    logic                    parity_q, parity_d;
`endif

    // Bit timer is held at zero while idle so START always gets a full bit.
    assign restart_c = (state_q == IDLE);

    uart_baud_tick #(
        .CYCLES_PER_BIT(CYCLES_PER_BIT)
    ) u_baud_tick (
        .clk       (clk),
        .resetn    (resetn),
        .restart   (restart_c),
        .bit_done_c(bit_done_c)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (uart_tx_en) begin
                    state_d = START;
                    shift_d = uart_tx_data;
                    idx_d   = '0;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^uart_tx_data;
`endif
                end
            end
            START: begin
                if (bit_done_c) state_d = DATA;
            end
            DATA: begin
                if (bit_done_c) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == LAST_DATA) begin
                        idx_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_done_c) state_d = STOP;
            end
`endif
            STOP: begin
                // idx counts stop bits here
                if (bit_done_c) begin
                    if (idx_q == LAST_STOP) begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level follows the next state so the registered output moves on bit boundaries.
        txd_d = UART_IDLE_LEVEL;
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  txd_d = parity_d;
`endif
            default: txd_d = UART_IDLE_LEVEL;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            txd_q   <= UART_IDLE_LEVEL;
            busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign uart_txd     = txd_q;
    assign uart_tx_busy = busy_q;

endmodule
